// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache: combinational hit path, three-state miss
// handler that fetches a 16-byte block from instruction memory and installs it.
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT,
  output logic [1:0]   fsm_state
);
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, UPDATE = 2'd2} state_t;

  state_t                state;
  logic                  first_wait;
  logic [127:0]          fill_data;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [127:0]          data [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  hit;
  logic [127:0]          line_data;
  logic [31:0]           word;
  logic                  unused_byte_offset;

  assign index              = ADDRESS[4 +: INDEX_BITS];
  assign tag                = ADDRESS[31 -: TAG_BITS];
  assign miss_index         = MEM_ADDRESS[INDEX_BITS-1:0];
  assign miss_tag           = MEM_ADDRESS[27 -: TAG_BITS];
  assign hit                = valid[index] && (tags[index] == tag);
  assign line_data          = data[index];
  assign word               = line_data[{ADDRESS[3:2], 5'b0} +: 32];
  assign fsm_state          = state;
  assign unused_byte_offset = ^ADDRESS[1:0];

  // Stall is gated by RESET so a fetch presented during reset never stalls.
  always_comb begin
    BUSYWAIT    = 1'b0;
    INSTRUCTION = 32'h0;
    if (RESET) begin
      if (state != IDLE) begin
        BUSYWAIT = 1'b1;
      end else if (READ) begin
        if (hit) INSTRUCTION = word;
        else     BUSYWAIT    = 1'b1;
      end
    end
  end

  // MEM_ADDRESS doubles as the miss latch; it supplies index and tag for the fill.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      first_wait  <= 1'b0;
      fill_data   <= '0;
      valid       <= '0;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (READ && !hit) begin
            MEM_ADDRESS <= ADDRESS[31:4];
            MEM_READ    <= 1'b1;
            first_wait  <= 1'b1;
            state       <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // The first edge is ignored: memory has not yet seen MEM_READ.
          first_wait <= 1'b0;
          if (!first_wait && !MEM_BUSYWAIT) begin
            fill_data <= MEM_READDATA;
            MEM_READ  <= 1'b0;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          valid[miss_index] <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (state == UPDATE) begin
      tags[miss_index] <= miss_tag;
      data[miss_index] <= fill_data;
    end
  end
endmodule
